fnc_uart_rx: RTL and testbench

FNC_UART_RX -- requirements
Module: fnc_uart_rx

---
 rtl/fnc_uart_rx.sv | 127 ++++++++++++
 tb/tb_fnc_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fnc_uart_rx.sv
// 8N1 UART receiver: synchronized rxd, mid-bit sampling at N clocks per bit,
// single-entry holding register with sticky framing and overrun flags.
module fnc_uart_rx #(
    parameter int SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_en,
    input  logic [31:0] refclk_st,
    input  logic        rxd,
    input  logic        rx_rd,
    input  logic        rx_clr,
    output logic [7:0]  rx_data,
    output logic        rx_full,
    output logic        rx_valid,
    output logic        rx_ferr,
    output logic        rx_ovr,
    output logic        rx_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;
    logic [31:0]         r_n;
    logic [31:0]         r_cnt;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;

    logic w_rxd_s;
    logic w_fall;
    logic w_tick_half;
    logic w_tick_bit;
    logic w_stop_smp;
    logic w_load;
    logic w_ovr_set;
    logic w_ferr_set;

    assign w_rxd_s     = r_sync[SYNC_STG-1];
    assign w_fall      = r_prev & ~w_rxd_s;
    assign w_tick_half = (r_cnt == ({1'b0, r_n[31:1]} - 32'd1));
    assign w_tick_bit  = (r_cnt == (r_n - 32'd1));
    // A disabled receiver never reaches its stop sample.
    assign w_stop_smp  = uart_en & (r_state == S_STOP) & w_tick_bit;
    assign w_load      = w_stop_smp & w_rxd_s & (~rx_full | rx_rd);
    assign w_ovr_set   = w_stop_smp & w_rxd_s & rx_full & ~rx_rd;
    assign w_ferr_set  = w_stop_smp & ~w_rxd_s;

    assign rx_busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sync   <= '1;
            r_prev   <= 1'b1;
            r_n      <= 32'd0;
            r_cnt    <= 32'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'h00;
            rx_data  <= 8'h00;
            rx_full  <= 1'b0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STG-2:0], rxd};
            r_prev   <= w_rxd_s;
            rx_valid <= w_load;
            rx_full  <= w_load | (rx_full & ~rx_rd);
            rx_ferr  <= w_ferr_set | (rx_ferr & ~rx_clr);
            rx_ovr   <= w_ovr_set | (rx_ovr & ~rx_clr);
            if (w_load) begin
                rx_data <= r_shift;
            end
            if (!uart_en) begin
                r_state <= S_IDLE;
                r_cnt   <= 32'd0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_cnt <= 32'd0;
                        if (w_fall) begin
                            r_state <= S_START;
                            r_n     <= refclk_st;
                        end
                    end
                    S_START: begin
                        if (w_tick_half) begin
                            r_cnt   <= 32'd0;
                            r_bit   <= 3'd0;
                            r_state <= w_rxd_s ? S_IDLE : S_DATA;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_tick_bit) begin
                            r_cnt   <= 32'd0;
                            r_shift <= {w_rxd_s, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_STOP: begin
                        if (w_tick_bit) begin
                            r_cnt   <= 32'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fnc_uart_rx.sv
// Bench for fnc_uart_rx: directed frames plus random frames scored
// against a frame-level model of the holding register and flags.
module tb_fnc_uart_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_en;
    logic [31:0] refclk_st;
    logic        rxd;
    logic        rx_rd;
    logic        rx_clr;
    logic [7:0]  rx_data;
    logic        rx_full;
    logic        rx_valid;
    logic        rx_ferr;
    logic        rx_ovr;
    logic        rx_busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int vcnt  = 0;
    int vcyc  = 0;

    logic [7:0] m_data;
    bit         m_full;
    bit         m_ferr;
    bit         m_ovr;
    int         m_vcnt;

    fnc_uart_rx #(.SYNC_STG(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_en  (uart_en),
        .refclk_st(refclk_st),
        .rxd      (rxd),
        .rx_rd    (rx_rd),
        .rx_clr   (rx_clr),
        .rx_data  (rx_data),
        .rx_full  (rx_full),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_ovr   (rx_ovr),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt <= vcnt + 1;
            vcyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_data"}, rx_data, m_data);
        chk({tag, "_full"}, rx_full, m_full);
        chk({tag, "_ferr"}, rx_ferr, m_ferr);
        chk({tag, "_ovr"}, rx_ovr, m_ovr);
        chk({tag, "_vcnt"}, vcnt, m_vcnt);
        chk({tag, "_busy"}, rx_busy, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_full"}, rx_full, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_ferr"}, rx_ferr, 0);
        chk({tag, "_ovr"}, rx_ovr, 0);
        chk({tag, "_busy"}, rx_busy, 0);
    endtask

    task automatic pulse_rd();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd  = 1'b0;
        m_full = 1'b0;
    endtask

    task automatic pulse_clr();
        rx_clr = 1'b1;
        @(negedge clk);
        rx_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Drives one ideal frame, N clocks per bit, then 2N idle clocks.
    task automatic frame(input string tag, input logic [7:0] b,
                         input logic stop, input int n, input int rd_at,
                         input int rst_at, input int abort_at,
                         input bit nchg);
        logic [9:0] bits;
        int t0;
        int lat;
        bits      = {stop, b, 1'b0};
        refclk_st = n;
        t0        = cyc;
        for (int c = 0; c < 10 * n; c++) begin
            rxd   = bits[c / n];
            rx_rd = (c == rd_at);
            rst   = (c == rst_at);
            if (c == abort_at) uart_en = 1'b0;
            if (nchg && c == 3 * n) refclk_st = $urandom_range(4, 40);
            @(negedge clk);
            if (c == rst_at) begin
                check_reset({tag, "_rst"});
                m_data = 8'h00;
                m_full = 1'b0;
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (abort_at >= 0 && c == abort_at + 1)
                chk({tag, "_abort_busy"}, rx_busy, 0);
        end
        rxd     = 1'b1;
        rx_rd   = 1'b0;
        rst     = 1'b0;
        uart_en = 1'b1;
        repeat (2 * n) @(negedge clk);
        if (rst_at < 0 && abort_at < 0) begin
            if (rd_at >= 0) m_full = 1'b0;
            if (!stop) begin
                m_ferr = 1'b1;
            end else if (m_full) begin
                m_ovr = 1'b1;
            end else begin
                m_data = b;
                m_full = 1'b1;
                m_vcnt++;
                lat = vcyc - t0;
                chk({tag, "_lat_ok"},
                    (lat >= 9 * n + n / 2 && lat <= 9 * n + n / 2 + SYNC + 3)
                        ? 1 : 0, 1);
            end
        end
        check_state(tag);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        logic stp;
        rst       = 1'b1;
        uart_en   = 1'b1;
        rxd       = 1'b1;
        rx_rd     = 1'b0;
        rx_clr    = 1'b0;
        refclk_st = 32'd16;
        m_data    = 8'h00;
        m_full    = 1'b0;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
        m_vcnt    = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame("b55", 8'h55, 1'b1, 16, -1, -1, -1, 1'b0);

        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        chk("glitch_busy_on", rx_busy, 1);
        repeat (30) @(negedge clk);
        check_state("glitch");

        pulse_rd();
        chk("rd_full", rx_full, 0);
        frame("ferr", 8'hA3, 1'b0, 16, -1, -1, -1, 1'b0);
        pulse_clr();
        check_state("ferr_clr");

        frame("b11", 8'h11, 1'b1, 16, -1, -1, -1, 1'b0);
        frame("ovr22", 8'h22, 1'b1, 16, -1, -1, -1, 1'b0);
        frame("rd22", 8'h22, 1'b1, 16, SYNC + 8 + 144, -1, -1, 1'b0);
        pulse_clr();

        pulse_rd();
        frame("abort", 8'hC3, 1'b1, 16, -1, -1, 5 * 16 + 8, 1'b0);
        frame("b7e", 8'h7E, 1'b1, 16, -1, -1, -1, 1'b0);

        frame("stoprst", 8'h99, 1'b1, 16, -1, 9 * 16 + 3, -1, 1'b0);
        frame("b0f", 8'h0F, 1'b1, 16, -1, -1, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) pulse_rd();
            if ($urandom_range(0, 3) == 0) pulse_clr();
            n   = $urandom_range(6, 20);
            b   = 8'($urandom);
            stp = ($urandom_range(0, 5) != 0);
            frame("rnd", b, stp, n, -1, -1, -1,
                  ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
